parity_frame_ctrl: RTL and testbench
====================================

// Module: parity_frame_ctrl
// PURPOSE
//  Frame-level controller around the serial parity datapath: on start, accumulates
//  DATA_BITS serial bits, then samples the trailing parity bit and checks it.
//  Reports done/par_err per frame. Sits between the serial receive shifter and the
//  link status logic; one frame in flight at a time.
// PARAMETERS
//  DATA_BITS   8   data bits per frame (>=1), parity bit follows last data bit
//  ODD_PARITY  0   0: even parity expected (total ones incl. parity bit even); 1: odd
//  CNT_W       8   width of err_count (PARITY_STATS_EN only)
// PORTS
//  clk        in   1      rising-edge clock, single clock domain
//  rst        in   1      synchronous reset, active-high
//  start      in   1      begin a frame; honoured only in IDLE
//  x          in   1      serial bit (data bits LSB first, then parity bit)
//  x_valid    in   1      x is valid this cycle; bit consumed on the same edge
//  busy       out  1      1 in DATA or CHECK
//  parity     out  1      running XOR of data bits accepted in the current frame
//  done       out  1      one-cycle pulse: frame complete, par_err valid
//  par_err    out  1      1 = received parity bit mismatched; held until next start
//  err_count  out  CNT_W  saturating count of errored frames (PARITY_STATS_EN only)
// BEHAVIOUR
//  Reset (rst=1 at edge): state=IDLE; busy=0, parity=0, done=0, par_err=0,
//   bit_cnt=0, err_count=0. Reset mid-frame aborts the frame with no done pulse.
//  States: IDLE, DATA, CHECK, DONE (registered; all outputs registered/state-decoded).
//  IDLE : start=1 -> DATA; parity<=0, bit_cnt<=0, par_err<=0. x_valid ignored.
//  DATA : x_valid=1 -> parity<=parity^x, bit_cnt<=bit_cnt+1; if bit_cnt==DATA_BITS-1
//         -> CHECK. x_valid=0 -> hold (gaps of any length allowed).
//  CHECK: x_valid=1 -> par_err <= (parity^x) != ODD_PARITY; -> DONE.
//         x_valid=0 -> hold.
//  DONE : done=1 for exactly this one cycle; -> IDLE unconditionally.
//  Latency: done high in the cycle after the edge that consumed the parity bit.
//  start in DATA/CHECK/DONE ignored (no restart, no queueing); start in the IDLE
//   cycle right after DONE is accepted -> back-to-back frames, 1 idle cycle min.
//  parity holds its final value through DONE/IDLE until next accepted start.
//  bit_cnt width = $clog2(DATA_BITS+1); never wraps within a frame.
//  x, x_valid are don't-care in IDLE and DONE.
// CONFIGURATION
//  PARITY_STATS_EN defined: err_count port present; +1 on the edge entering DONE
//   with mismatch; saturates at {CNT_W{1'b1}}; cleared only by rst.
//  PARITY_STATS_EN undefined: err_count port and counter absent; rest identical.
// TESTING
//  1 rst 2 cycles -> all outputs 0, busy=0; start, x=1010_0101 LSB first, parity bit 0
//    (ODD_PARITY=0) -> parity=0, done pulse 1 cycle, par_err=0.
//  2 Same data, parity bit 1 -> done pulse, par_err=1, held through 5 idle cycles;
//    next start clears par_err to 0.
//  3 Frame 0xFF with x_valid=0 for 3 cycles between each bit -> busy stays 1, result
//    identical to gapless case (par_err=0 with parity bit 0); done only after 9th valid bit.
//  4 start pulsed again mid-DATA and during DONE -> ignored, bit_cnt unaffected,
//    exactly one done per frame; start in IDLE right after DONE starts new frame.
//  5 rst asserted after 4 data bits -> next cycle IDLE, busy=0, no done; new frame OK.
//  6 PARITY_STATS_EN, CNT_W=2: 4 errored frames + 1 clean -> err_count 1,2,3,3,3;
//    ODD_PARITY=1 with 0x01 + parity 0 -> par_err=0.

Source files
------------

// File: rtl/parity_frame_if.sv
// Serial parity frame bus between the receive shifter and the frame controller.
// err_count exists only when PARITY_STATS_EN is defined.
interface parity_frame_if
`ifdef PARITY_STATS_EN
  #(parameter int CNT_W = 8)
`endif
  ;
  logic start;
  logic x;
  logic x_valid;
  logic busy;
  logic parity;
  logic done;
  logic par_err;
`ifdef PARITY_STATS_EN
  logic [CNT_W-1:0] err_count;
`endif

  modport master (
    output start, x, x_valid,
    input  busy, parity, done, par_err
`ifdef PARITY_STATS_EN
    , err_count
`endif
  );

  modport slave (
    input  start, x, x_valid,
    output busy, parity, done, par_err
`ifdef PARITY_STATS_EN
    , err_count
`endif
  );
endinterface

// File: rtl/parity_frame_ctrl.sv
// Frame controller: collects DATA_BITS serial bits, checks the trailing parity bit.
// Optional saturating errored-frame counter enabled by defining PARITY_STATS_EN.
module parity_frame_ctrl #(
  parameter int DATA_BITS  = 8,
  parameter int ODD_PARITY = 0
`ifdef PARITY_STATS_EN
  , parameter int CNT_W    = 8
`endif
) (
  input  logic           clk,
  input  logic           rst,
  parity_frame_if.slave  pf,
  output logic [1:0]     state_dbg
);

  localparam int BW = $clog2(DATA_BITS + 1);
  localparam logic [BW-1:0] LAST_BIT = BW'(DATA_BITS - 1);
  localparam logic ODD_BIT = (ODD_PARITY != 0);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_DATA  = 2'd1,
    S_CHECK = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t        state;
  logic [BW-1:0] bit_cnt;
  logic          parity_q;
  logic          par_err_q;
  logic          busy_q;
  logic          done_q;
  logic          mismatch;

  // Valid semantics: x is consumed on any edge where x_valid=1 while in DATA or
  // CHECK; there is no back-pressure, and x/x_valid are ignored in IDLE and DONE.
  assign mismatch = ((parity_q ^ pf.x) != ODD_BIT);

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      bit_cnt   <= '0;
      parity_q  <= 1'b0;
      par_err_q <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state)
        S_IDLE: begin
          if (pf.start) begin
            state     <= S_DATA;
            busy_q    <= 1'b1;
            parity_q  <= 1'b0;
            bit_cnt   <= '0;
            par_err_q <= 1'b0;
          end
        end
        S_DATA: begin
          if (pf.x_valid) begin
            parity_q <= parity_q ^ pf.x;
            bit_cnt  <= bit_cnt + 1'b1;
            if (bit_cnt == LAST_BIT) state <= S_CHECK;
          end
        end
        S_CHECK: begin
          // parity_q is left at the data-only XOR so it stays visible after the frame
          if (pf.x_valid) begin
            par_err_q <= mismatch;
            state     <= S_DONE;
            busy_q    <= 1'b0;
            done_q    <= 1'b1;
          end
        end
        S_DONE: begin
          state <= S_IDLE;
        end
        default: begin
          state  <= S_IDLE;
          busy_q <= 1'b0;
        end
      endcase
    end
  end

`ifdef PARITY_STATS_EN
  logic [CNT_W-1:0] err_cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      err_cnt_q <= '0;
    end else if (state == S_CHECK && pf.x_valid && mismatch && err_cnt_q != {CNT_W{1'b1}}) begin
      err_cnt_q <= err_cnt_q + 1'b1;
    end
  end

  assign pf.err_count = err_cnt_q;
`endif

  assign pf.busy    = busy_q;
  assign pf.parity  = parity_q;
  assign pf.done    = done_q;
  assign pf.par_err = par_err_q;
  assign state_dbg  = state;

endmodule

// File: tb/tb_parity_frame_ctrl.sv
// Bench for parity_frame_ctrl: an even-parity and an odd-parity instance share one
// randomized stimulus stream; expectations come from bit counting in the bench.
module tb_parity_frame_ctrl;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

`ifdef PARITY_STATS_EN
  parity_frame_if #(.CNT_W(8)) pf0();
  parity_frame_if #(.CNT_W(2)) pf1();
`else
  parity_frame_if pf0();
  parity_frame_if pf1();
`endif

  logic [1:0] st0, st1;

  parity_frame_ctrl #(
    .DATA_BITS(8), .ODD_PARITY(0)
`ifdef PARITY_STATS_EN
    , .CNT_W(8)
`endif
  ) dut0 (.clk(clk), .rst(rst), .pf(pf0), .state_dbg(st0));

  parity_frame_ctrl #(
    .DATA_BITS(8), .ODD_PARITY(1)
`ifdef PARITY_STATS_EN
    , .CNT_W(2)
`endif
  ) dut1 (.clk(clk), .rst(rst), .pf(pf1), .state_dbg(st1));

  int n_checks = 0;
  int n_errs   = 0;
  logic [1:0] exp_q[$];
  logic [1:0] mon_e;
  int cnt0 = 0;
  int cnt1 = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errs++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic drive(input logic s, input logic v, input logic b);
    pf0.start = s; pf1.start = s;
    pf0.x_valid = v; pf1.x_valid = v;
    pf0.x = b; pf1.x = b;
  endtask

  // Scoreboard: every done pulse must match the oldest queued {odd_err, even_err}.
  always @(negedge clk) begin
    if (!rst && (pf0.done || pf1.done)) begin
      check("done_pair", 32'(pf1.done), 32'(pf0.done));
      if (exp_q.size() == 0) begin
        check("spurious_done", 32'(pf0.done), 32'd0);
      end else begin
        mon_e = exp_q.pop_front();
        check("par_err_frame", 32'({pf1.par_err, pf0.par_err}), 32'(mon_e));
      end
    end
  end

  // Entered and left on a negedge with the DUTs in IDLE.
  task automatic send_frame(input logic [7:0] data, input logic pbit,
                            input int gmin, input int gmax, input bit noise);
    int ones;
    int g;
    logic e0, e1;
    drive(1'b1, 1'($urandom), 1'($urandom));
    @(negedge clk);
    check("busy_start", 32'(pf0.busy), 32'd1);
    check("parity_clr", 32'(pf0.parity), 32'd0);
    check("par_err_clr0", 32'(pf0.par_err), 32'd0);
    check("par_err_clr1", 32'(pf1.par_err), 32'd0);
    ones = 0;
    for (int i = 0; i < 9; i++) begin
      g = $urandom_range(gmax, gmin);
      repeat (g) begin
        drive(noise ? 1'($urandom) : 1'b0, 1'b0, 1'($urandom));
        @(negedge clk);
        check("busy_gap", 32'(pf0.busy), 32'd1);
      end
      if (i < 8) begin
        drive(noise && i == 3, 1'b1, data[i]);
        @(negedge clk);
        ones += int'(data[i]);
        check("parity_run0", 32'(pf0.parity), 32'(ones % 2));
        check("parity_run1", 32'(pf1.parity), 32'(ones % 2));
        check("busy_data", 32'(pf0.busy), 32'd1);
      end
    end
    e0 = ((ones + int'(pbit)) % 2) != 0;
    e1 = ((ones + int'(pbit)) % 2) != 1;
    exp_q.push_back({e1, e0});
    drive(1'b0, 1'b1, pbit);
    @(negedge clk);
    check("done_latency", 32'(pf0.done), 32'd1);
    check("busy_done", 32'(pf0.busy), 32'd0);
    check("parity_final", 32'(pf0.parity), 32'(ones % 2));
`ifdef PARITY_STATS_EN
    if (e0 && cnt0 < 255) cnt0++;
    if (e1 && cnt1 < 3) cnt1++;
    check("err_count0", 32'(pf0.err_count), 32'(cnt0));
    check("err_count1", 32'(pf1.err_count), 32'(cnt1));
`endif
    drive(noise, 1'($urandom), 1'($urandom));
    @(negedge clk);
    check("done_one_cycle", 32'(pf0.done), 32'd0);
    check("busy_idle", 32'(pf0.busy), 32'd0);
    check("par_err_hold0", 32'(pf0.par_err), 32'(e0));
    check("par_err_hold1", 32'(pf1.par_err), 32'(e1));
    drive(1'b0, 1'b0, 1'b0);
  endtask

  task automatic idle_cycles(input int n, input logic e0, input logic e1);
    repeat (n) begin
      drive(1'b0, 1'($urandom), 1'($urandom));
      @(negedge clk);
      check("idle_busy", 32'(pf0.busy), 32'd0);
      check("idle_err0", 32'(pf0.par_err), 32'(e0));
      check("idle_err1", 32'(pf1.par_err), 32'(e1));
    end
    drive(1'b0, 1'b0, 1'b0);
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_busy"}, 32'({pf1.busy, pf0.busy}), 32'd0);
    check({tag, "_parity"}, 32'({pf1.parity, pf0.parity}), 32'd0);
    check({tag, "_done"}, 32'({pf1.done, pf0.done}), 32'd0);
    check({tag, "_par_err"}, 32'({pf1.par_err, pf0.par_err}), 32'd0);
`ifdef PARITY_STATS_EN
    check({tag, "_err_count0"}, 32'(pf0.err_count), 32'd0);
    check({tag, "_err_count1"}, 32'(pf1.err_count), 32'd0);
`endif
  endtask

  task automatic abort_frame();
    drive(1'b1, 1'b0, 1'b0);
    @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      drive(1'b0, 1'b1, 1'($urandom));
      @(negedge clk);
    end
    rst = 1'b1;
    drive(1'b0, 1'b0, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    cnt0 = 0;
    cnt1 = 0;
    check_reset_state("abort");
    idle_cycles(3, 1'b0, 1'b0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] d;
    logic p;
    rst = 1'b1;
    drive(1'b0, 1'b0, 1'b0);
    repeat (2) @(negedge clk);
    check_reset_state("reset");
    rst = 1'b0;
    @(negedge clk);

    send_frame(8'hA5, 1'b0, 0, 0, 1'b0);
    send_frame(8'hA5, 1'b1, 0, 0, 1'b0);
    idle_cycles(5, 1'b1, 1'b0);
    send_frame(8'hFF, 1'b0, 3, 3, 1'b0);
    send_frame(8'h3C, 1'b1, 0, 1, 1'b1);
    send_frame(8'h5A, 1'b0, 0, 1, 1'b1);
    abort_frame();

    repeat (4) send_frame(8'h00, 1'b0, 0, 1, 1'b0);
    send_frame(8'h01, 1'b0, 0, 1, 1'b0);

    for (int k = 0; k < 30; k++) begin
      d = 8'($urandom);
      p = 1'($urandom);
      send_frame(d, p, 0, 2, 1'($urandom));
      repeat ($urandom_range(2, 0)) begin
        drive(1'b0, 1'($urandom), 1'($urandom));
        @(negedge clk);
      end
      drive(1'b0, 1'b0, 1'b0);
    end

    @(negedge clk);
    check("exp_q_drained", 32'(exp_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errs);
    $finish;
  end

endmodule
